// File: rtl/multicycle_datapath_if.sv
// multicycle_datapath_if
//   Bus bundle for the multi-cycle RISC-V datapath.
//   Instruction-memory load port (driven by the master, typically a bench):
//     imem_we     - write strobe, honoured in every cycle including reset
//     imem_addr   - word index into instruction memory
//     imem_wdata  - 32-bit instruction word
//   Observation port (driven by the datapath):
//     nextPC      - current PC register
//     ALUResult   - ALUOut register
//     instruction - IR register
//     state       - controller state (FETCH=0 .. WB=4)
//     instr_done  - one-cycle pulse in the final state of each instruction
//     illegal     - one-cycle pulse, together with instr_done, for an unsupported encoding
interface multicycle_datapath_if #(
  parameter int XLEN    = 64,
  parameter int IMEM_AW = 6
);
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic [XLEN-1:0]    nextPC;
  logic [XLEN-1:0]    ALUResult;
  logic [31:0]        instruction;
  logic [2:0]         state;
  logic               instr_done;
  logic               illegal;

  modport master (
    output imem_we, imem_addr, imem_wdata,
    input  nextPC, ALUResult, instruction, state, instr_done, illegal
  );

  modport slave (
    input  imem_we, imem_addr, imem_wdata,
    output nextPC, ALUResult, instruction, state, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multi-cycle RISC-V datapath: a five-state controller (FETCH, DECODE, EXEC,
//   MEM, WB) sequences one shared ALU. IR, A, B, ALUOut and MDR carry values
//   between states. Instruction memory, data memory and a 32-entry register
//   file are internal.
//   Supported: add, sub, and, or, addi, ld/sd (XLEN=64) or lw/sw (XLEN=32), beq.
//   Anything else runs as a NOP through WB with an illegal pulse.
// Parameters:
//   XLEN       - datapath width, 32 or 64
//   IMEM_WORDS - instruction memory depth in 32-bit words (power of 2)
//   DMEM_WORDS - data memory depth in XLEN-bit words (power of 2)
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high; memories keep their contents
//   bus   - multicycle_datapath_if.slave (imem load port + observation outputs)
// Build option:
//   MULTICYCLE_BNE_EN - when defined, funct3 001 under the branch opcode is bne;
//                       otherwise that encoding is illegal.
module multicycle_datapath #(
  parameter int XLEN       = 64,
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_datapath_if.slave bus
);
  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);
  localparam int BYTE_SH = $clog2(XLEN / 8);

  // Load/store width selector: doubleword for RV64, word for RV32
  localparam logic [2:0]      LS_F3   = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'b100);
  localparam logic [XLEN-1:0] ZERO_X  = {XLEN{1'b0}};

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d;
  logic [XLEN-1:0] mdr_q, mdr_d;
  logic            instr_done_q, instr_done_d;
  logic            illegal_q, illegal_d;

  logic [31:0]     imem [IMEM_WORDS];
  logic [XLEN-1:0] dmem [DMEM_WORDS];
  logic [XLEN-1:0] rf_q [32];

  // Decode
  logic [6:0]      opcode_s;
  logic [4:0]      rd_s, rs1_s, rs2_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic            is_alu_r_s, is_addi_s, is_load_s, is_store_s;
  logic            is_beq_s, is_bne_s, is_branch_s, is_illegal_s;
  logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s;
  logic [XLEN-1:0] alu_res_s;
  logic            br_taken_s;

  // Memory / register-file control
  logic [IMEM_AW-1:0] fetch_idx_s;
  logic [DMEM_AW-1:0] dmem_idx_s;
  logic               dmem_we_s;
  logic               rf_we_s;
  logic [XLEN-1:0]    rf_wdata_s;

  assign opcode_s = ir_q[6:0];
  assign rd_s     = ir_q[11:7];
  assign funct3_s = ir_q[14:12];
  assign rs1_s    = ir_q[19:15];
  assign rs2_s    = ir_q[24:20];
  assign funct7_s = ir_q[31:25];

  assign is_alu_r_s = (opcode_s == OP_ALU) &&
                      (((funct3_s == 3'b000) && ((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000))) ||
                       ((funct3_s == 3'b111) && (funct7_s == 7'b0000000)) ||
                       ((funct3_s == 3'b110) && (funct7_s == 7'b0000000)));
  assign is_addi_s  = (opcode_s == OP_IMM)    && (funct3_s == 3'b000);
  assign is_load_s  = (opcode_s == OP_LOAD)   && (funct3_s == LS_F3);
  assign is_store_s = (opcode_s == OP_STORE)  && (funct3_s == LS_F3);
  assign is_beq_s   = (opcode_s == OP_BRANCH) && (funct3_s == 3'b000);
`ifdef MULTICYCLE_BNE_EN
  assign is_bne_s   = (opcode_s == OP_BRANCH) && (funct3_s == 3'b001);
`else
  assign is_bne_s   = 1'b0;
`endif
  assign is_branch_s  = is_beq_s | is_bne_s;
  assign is_illegal_s = !(is_alu_r_s | is_addi_s | is_load_s | is_store_s | is_branch_s);

  assign imm_i_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b_s = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  // PC bits [1:0] are ignored and high bits wrap over the memory depth
  assign fetch_idx_s = pc_q[IMEM_AW+1:2];
  assign dmem_idx_s  = DMEM_AW'(alu_out_q >> BYTE_SH);

  // Shared ALU: operand selection and operation from the decoded instruction
  always_comb begin
    alu_res_s = a_q + imm_i_s;
    if (is_alu_r_s) begin
      case (funct3_s)
        3'b000:  alu_res_s = funct7_s[5] ? (a_q - b_q) : (a_q + b_q);
        3'b111:  alu_res_s = a_q & b_q;
        3'b110:  alu_res_s = a_q | b_q;
        default: alu_res_s = a_q + b_q;
      endcase
    end else if (is_store_s) begin
      alu_res_s = a_q + imm_s_s;
    end else if (is_branch_s) begin
      alu_res_s = a_q - b_q;
    end else begin
      alu_res_s = a_q + imm_i_s;
    end
  end

  assign br_taken_s = is_beq_s ? (a_q == b_q) : (a_q != b_q);

  // Controller: next state, datapath register loads and write strobes
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    alu_out_d    = alu_out_q;
    mdr_d        = mdr_q;
    instr_done_d = 1'b0;
    illegal_d    = 1'b0;
    dmem_we_s    = 1'b0;
    rf_we_s      = 1'b0;
    rf_wdata_s   = alu_out_q;
    case (state_q)
      S_FETCH: begin
        // Combinational read of the array: a same-cycle imem write lands after IR latches
        ir_d    = imem[fetch_idx_s];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d          = (rs1_s == 5'd0) ? ZERO_X : rf_q[rs1_s];
        b_d          = (rs2_s == 5'd0) ? ZERO_X : rf_q[rs2_s];
        state_d      = S_EXEC;
        // done/illegal are registered, so they are raised on entry to the final state
        instr_done_d = is_branch_s;
      end
      S_EXEC: begin
        alu_out_d = alu_res_s;
        if (is_branch_s) begin
          pc_d    = br_taken_s ? (pc_q + imm_b_s) : (pc_q + PC_STEP);
          state_d = S_FETCH;
        end else if (is_load_s || is_store_s) begin
          state_d      = S_MEM;
          instr_done_d = is_store_s;
        end else begin
          state_d      = S_WB;
          instr_done_d = 1'b1;
          illegal_d    = is_illegal_s;
        end
      end
      S_MEM: begin
        if (is_store_s) begin
          dmem_we_s = 1'b1;
          pc_d      = pc_q + PC_STEP;
          state_d   = S_FETCH;
        end else begin
          mdr_d        = dmem[dmem_idx_s];
          state_d      = S_WB;
          instr_done_d = 1'b1;
        end
      end
      S_WB: begin
        rf_we_s    = (is_alu_r_s || is_addi_s || is_load_s) && (rd_s != 5'd0);
        rf_wdata_s = is_load_s ? mdr_q : alu_out_q;
        pc_d       = pc_q + PC_STEP;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Controller state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= ZERO_X;
      ir_q         <= 32'h0000_0000;
      a_q          <= ZERO_X;
      b_q          <= ZERO_X;
      alu_out_q    <= ZERO_X;
      mdr_q        <= ZERO_X;
      instr_done_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      alu_out_q    <= alu_out_d;
      mdr_q        <= mdr_d;
      instr_done_q <= instr_done_d;
      illegal_q    <= illegal_d;
    end
  end

  // Register file: cleared by reset, one write port used in WB
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= ZERO_X;
      end
    end else if (rf_we_s) begin
      rf_q[rd_s] <= rf_wdata_s;
    end
  end

  // Instruction memory write port; stays live through reset so programs can be loaded
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      imem[bus.imem_addr] <= bus.imem_wdata;
    end
  end

  // Data memory write port; a store caught by reset is dropped
  always_ff @(posedge clk) begin
    if (dmem_we_s && !reset) begin
      dmem[dmem_idx_s] <= b_q;
    end
  end

  assign bus.nextPC      = pc_q;
  assign bus.ALUResult   = alu_out_q;
  assign bus.instruction = ir_q;
  assign bus.state       = state_q;
  assign bus.instr_done  = instr_done_q;
  assign bus.illegal     = illegal_q;
endmodule
